// File: rtl/vga_if.sv
// Pixel bus carried down the draw pipeline: raster position, sync/blank strobes and colour.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing.sv
// Free-running VGA raster counters with registered sync/blank strobes, a start-of-frame pulse
// and a completed-frame counter; strobes are decoded from the next counts so nothing lags hcount.
module vga_timing #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  vga_if.out          vga_out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic        line_end;
  logic        frame_end;
  logic        hsync_nxt;
  logic        vsync_nxt;
  logic        hblnk_nxt;
  logic        vblnk_nxt;

  always_comb begin
    line_end  = (vga_out.hcount == 11'(H_TOTAL - 1));
    frame_end = line_end && (vga_out.vcount == 11'(V_TOTAL - 1));
    h_nxt     = line_end ? 11'd0 : vga_out.hcount + 11'd1;
    if (frame_end)
      v_nxt = 11'd0;
    else if (line_end)
      v_nxt = vga_out.vcount + 11'd1;
    else
      v_nxt = vga_out.vcount;

    // Strobes come from the next counts so they land on the same edge as the counters.
    hblnk_nxt = (h_nxt >= 11'(H_ACTIVE));
    vblnk_nxt = (v_nxt >= 11'(V_ACTIVE));
    hsync_nxt = ((h_nxt >= 11'(H_ACTIVE + H_FP)) && (h_nxt < 11'(H_ACTIVE + H_FP + H_SYNC)))
                ? HSYNC_POL : ~HSYNC_POL;
    vsync_nxt = ((v_nxt >= 11'(V_ACTIVE + V_FP)) && (v_nxt < 11'(V_ACTIVE + V_FP + V_SYNC)))
                ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vga_out.hcount <= 11'd0;
      vga_out.vcount <= 11'd0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hsync  <= ~HSYNC_POL;
      vga_out.vsync  <= ~VSYNC_POL;
      frame_start    <= 1'b0;
      frame_cnt      <= 16'd0;
    end else if (en) begin
      vga_out.hcount <= h_nxt;
      vga_out.vcount <= v_nxt;
      vga_out.hblnk  <= hblnk_nxt;
      vga_out.vblnk  <= vblnk_nxt;
      vga_out.hsync  <= hsync_nxt;
      vga_out.vsync  <= vsync_nxt;
      frame_start    <= frame_end;
      frame_cnt      <= frame_cnt + 16'(frame_end);
    end else begin
      frame_start    <= 1'b0;
    end
  end

  assign vga_out.rgb = 12'h000;

endmodule

// File: tb/tb_vga_timing.sv
// Bench: default-timing instance for line-level edges, small inverted-polarity instance for frames.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b0, en0 = 1'b1;
  logic rst1 = 1'b0, en1 = 1'b1;
  logic        fs0, fs1;
  logic [15:0] fc0, fc1;

  vga_if bus0 ();
  vga_if bus1 ();

  vga_timing dut0 (
    .clk(clk), .rst(rst0), .en(en0), .vga_out(bus0), .frame_start(fs0), .frame_cnt(fc0)
  );

  vga_timing #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .vga_out(bus1), .frame_start(fs1), .frame_cnt(fc1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: raster position as a linear pixel index within the frame.
  function automatic logic [63:0] expv(input int p, input bit fs, input int fc,
                                       input int ht, input int ha, input int hf, input int hsn,
                                       input int va, input int vf, input int vsn,
                                       input bit hp, input bit vp);
    int   h;
    int   v;
    logic hs;
    logic vs;
    h  = p % ht;
    v  = p / ht;
    hs = (h >= ha + hf && h < ha + hf + hsn) ? hp : ~hp;
    vs = (v >= va + vf && v < va + vf + vsn) ? vp : ~vp;
    return {9'd0, 11'(h), 11'(v), hs, vs, (h >= ha), (v >= va), 12'h000, fs, 16'(fc)};
  endfunction

  int p0 = 0, m_fc0 = 0; bit m_fs0 = 0, ok0 = 0;
  int p1 = 0, m_fc1 = 0; bit m_fs1 = 0, ok1 = 0;

  always @(posedge clk) begin
    if (!rst0) begin
      p0 = 0; m_fc0 = 0; m_fs0 = 0; ok0 = 1;
    end else if (en0) begin
      p0 = (p0 + 1) % (1056 * 628);
      m_fs0 = (p0 == 0);
      if (m_fs0) m_fc0 = (m_fc0 + 1) % 65536;
    end else m_fs0 = 0;

    if (!rst1) begin
      p1 = 0; m_fc1 = 0; m_fs1 = 0; ok1 = 1;
    end else if (en1) begin
      p1 = (p1 + 1) % (32 * 20);
      m_fs1 = (p1 == 0);
      if (m_fs1) m_fc1 = (m_fc1 + 1) % 65536;
    end else m_fs1 = 0;
  end

  always @(negedge clk) begin
    if (ok0)
      chk("model0",
          {9'd0, bus0.hcount, bus0.vcount, bus0.hsync, bus0.vsync, bus0.hblnk, bus0.vblnk,
           bus0.rgb, fs0, fc0},
          expv(p0, m_fs0, m_fc0, 1056, 800, 40, 128, 600, 1, 4, 1'b1, 1'b1));
    if (ok1)
      chk("model1",
          {9'd0, bus1.hcount, bus1.vcount, bus1.hsync, bus1.vsync, bus1.hblnk, bus1.vblnk,
           bus1.rgb, fs1, fc1},
          expv(p1, m_fs1, m_fc1, 32, 16, 4, 8, 12, 2, 3, 1'b0, 1'b0));
  end

  initial begin
    int h, prev_h, hb_first, hs_cnt, hs_first, hs_last, wraps;
    int vb_h, vb_v, vs_min, vs_max, fs_cnt, hs1_first;

    // Default instance: reset at an arbitrary count.
    repeat (3) @(negedge clk);
    rst0 = 1'b1;
    repeat (123) @(negedge clk);
    rst0 = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_pos", {bus0.hcount, bus0.vcount}, {11'd0, 11'd0});
    chk("rst_strobes", {bus0.hsync, bus0.vsync, bus0.hblnk, bus0.vblnk}, 4'b0000);
    chk("rst_frame", {fs0, fc0}, 17'd0);

    rst0 = 1'b1;
    @(negedge clk);
    chk("first_edge", {bus0.hcount, bus0.vcount, fs0}, {11'd1, 11'd0, 1'b0});

    hb_first = -1; hs_cnt = 0; hs_first = -1; hs_last = -1; wraps = 0; prev_h = 1;
    for (int i = 0; i < 1056; i++) begin
      @(negedge clk);
      h = int'(bus0.hcount);
      if (bus0.hblnk && hb_first < 0) hb_first = h;
      if (bus0.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = h;
        hs_last = h;
      end
      if (prev_h == 1055 && h == 0 && bus0.vcount == 11'd1) wraps++;
      prev_h = h;
    end
    chk("hblnk_rise", hb_first, 800);
    chk("hsync_width", hs_cnt, 128);
    chk("hsync_first", hs_first, 840);
    chk("hsync_last", hs_last, 967);
    chk("line_wrap", wraps, 1);

    // Enable freeze just before the hsync window.
    for (int i = 0; i < 1100 && bus0.hcount != 11'd839; i++) @(negedge clk);
    chk("reach_839", bus0.hcount, 839);
    en0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("freeze_hold", {bus0.hcount, bus0.vcount, bus0.hsync, fs0}, {11'd839, 11'd1, 1'b0, 1'b0});
    en0 = 1'b1;
    @(negedge clk);
    chk("freeze_resume", {bus0.hcount, bus0.hsync}, {11'd840, 1'b1});

    // Small inverted-polarity instance, still in reset.
    chk("pol_rst", {bus1.hcount, bus1.vcount, bus1.hsync, bus1.vsync}, {11'd0, 11'd0, 1'b1, 1'b1});
    rst1 = 1'b1;
    vb_h = -1; vb_v = -1; vs_min = 99; vs_max = -1; fs_cnt = 0; hs1_first = -1;
    for (int i = 0; i < 640; i++) begin
      @(negedge clk);
      if (bus1.vblnk && vb_v < 0) begin vb_h = int'(bus1.hcount); vb_v = int'(bus1.vcount); end
      if (!bus1.vsync) begin
        if (int'(bus1.vcount) < vs_min) vs_min = int'(bus1.vcount);
        if (int'(bus1.vcount) > vs_max) vs_max = int'(bus1.vcount);
      end
      if (!bus1.hsync && hs1_first < 0) hs1_first = int'(bus1.hcount);
      if (fs1) fs_cnt++;
    end
    chk("vblnk_first", {vb_h[10:0], vb_v[10:0]}, {11'd0, 11'd12});
    chk("vsync_lo", vs_min, 14);
    chk("vsync_hi", vs_max, 16);
    chk("hsync_inv_first", hs1_first, 20);
    chk("frame_pulse", {fs_cnt[7:0], fs1, fc1, bus1.hcount, bus1.vcount},
        {8'd1, 1'b1, 16'd1, 11'd0, 11'd0});

    // Reset mid-frame with frame_cnt = 3.
    for (int i = 0; i < 3000 && !(fc1 == 16'd3 && bus1.hcount == 11'd10 && bus1.vcount == 11'd6); i++)
      @(negedge clk);
    chk("reach_mid", {fc1, bus1.hcount, bus1.vcount}, {16'd3, 11'd10, 11'd6});
    rst1 = 1'b0;
    @(negedge clk);
    chk("mid_rst", {bus1.hcount, bus1.vcount, fc1, fs1}, {11'd0, 11'd0, 16'd0, 1'b0});
    rst1 = 1'b1;
    @(negedge clk);
    chk("mid_rst_release", {bus1.hcount, fs1, fc1}, {11'd1, 1'b0, 16'd0});

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

VGA timing source at the head of the pixel pipeline. Drives `vga_if.out` with a zero `rgb` background; every draw stage downstream consumes it and forwards it unchanged or overlaid. Holds free-running horizontal/vertical counters and registers the sync/blank strobes decoded from them. Adds a start-of-frame pulse and a frame counter for frame-synchronous logic such as animation and latched parameters.

## Interface
Parameters (default 800x600 @ 60 Hz, 40 MHz pixel clock):
- `H_ACTIVE`, 800: visible pixels per line.
- `H_FP`, 40: horizontal front porch, in pixels.
- `H_SYNC`, 128: hsync width, in pixels.
- `H_BP`, 88: horizontal back porch (H_TOTAL = 1056).
- `V_ACTIVE`, 600: visible lines per frame.
- `V_FP`, 1: vertical front porch, in lines.
- `V_SYNC`, 4: vsync width, in lines.
- `V_BP`, 23: vertical back porch (V_TOTAL = 628).
- `HSYNC_POL`, 1: active level of hsync.
- `VSYNC_POL`, 1: active level of vsync.

Ports:
- `clk`  in  1  pixel clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `en`  in  1  count enable; when low, all outputs hold.
- `vga_out`  vga_if.out  —  fields: `hcount`[10:0], `vcount`[10:0], `hsync`, `vsync`, `hblnk`, `vblnk`, `rgb`[11:0].
- `frame_start`  out  1  one-cycle pulse when the counters enter (0,0).
- `frame_cnt`  out  16  number of completed frames; wraps.

## Operation
- Counters:
  - `hcount` counts 0..H_TOTAL-1.
  - When `hcount` = H_TOTAL-1, `hcount` returns to 0 and `vcount` advances.
  - `vcount` counts 0..V_TOTAL-1 and wraps to 0 after V_TOTAL-1 on a line wrap.
- Decode (a function of the `hcount`/`vcount` values on the bus in the same cycle):
  - `hblnk` = `hcount` >= H_ACTIVE.
  - `hsync` is at HSYNC_POL when H_ACTIVE+H_FP <= `hcount` < H_ACTIVE+H_FP+H_SYNC (defaults: 840..967), otherwise at !HSYNC_POL.
  - `vblnk` = `vcount` >= V_ACTIVE, held for whole lines.
  - `vsync` is at VSYNC_POL when V_ACTIVE+V_FP <= `vcount` < V_ACTIVE+V_FP+V_SYNC (defaults: 601..604), otherwise at !VSYNC_POL.
- Implementation: compute next counts combinationally, decode strobes from the next counts, and register counts and strobes in one `always_ff`. No output lags `hcount` by a cycle.
- `rgb` is always 12'h000.
- `frame_start`:
  - Asserted for exactly the one cycle in which the bus shows (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
  - Not asserted in the first cycle after reset.
- `frame_cnt` increments by 1 in the same cycle `frame_start` asserts; 16'hFFFF wraps to 0.
- `en` low: counters, strobes, `frame_cnt` hold; `frame_start` is 0.
- Widths: 11-bit counters must cover H_TOTAL-1 and V_TOTAL-1. The defaults need 1055 and 627, both below 2048.

## Timing
- Reset (any cycle `rst` = 0, including mid-frame) forces:
  - `hcount` = 0, `vcount` = 0, `hblnk` = 0, `vblnk` = 0, `rgb` = 0;
  - `hsync` = !HSYNC_POL, `vsync` = !VSYNC_POL;
  - `frame_start` = 0, `frame_cnt` = 0.
- First rising edge with `rst` = 1 and `en` = 1 moves the bus to (1,0).
- Line period is H_TOTAL enabled cycles; frame period is H_TOTAL*V_TOTAL (663168 with defaults).
- `hblnk` rises on the edge where `hcount` goes H_ACTIVE-1 -> H_ACTIVE, and falls on the wrap to 0.
- `vblnk`/`vsync` change only on the edge where `hcount` wraps to 0.
- Simultaneous `rst` = 0 and `en` = 1: reset wins.
- Latency from counter to strobe: 0 cycles, both are registered on the same edge.

## Test plan
- Reset: hold `rst` = 0 for 5 cycles at an arbitrary count -> bus reads (0,0), syncs at inactive levels, blanks 0, `frame_cnt` = 0, `frame_start` = 0.
- Horizontal edges, defaults, one line:
  - `hblnk` goes 0->1 exactly when `hcount` = 800.
  - `hsync` is 1 for `hcount` 840..967 inclusive (128 cycles).
  - `hcount` wraps 1055 -> 0 with `vcount` +1.
- Vertical edges:
  - `vblnk` is first 1 at (0,600).
  - `vsync` is 1 for `vcount` 601..604 only.
  - `vcount` wraps 627 -> 0; `frame_start` pulses once at (0,0); `frame_cnt` goes 0 -> 1 after 663168 cycles.
- Enable freeze: drop `en` for 10 cycles at (839,600) -> all outputs hold; with `en` high again, the next edge gives `hcount` 840 and `hsync` = 1.
- Reset mid-frame: assert `rst` = 0 for one cycle at (500,300) with `frame_cnt` = 3 -> (0,0), `frame_cnt` = 0, no `frame_start` pulse.
- Polarity: HSYNC_POL = 0, VSYNC_POL = 0 -> sync windows unchanged, levels inverted, reset levels 1.
